data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_resp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Word-addressed 32-bit data memory serving the MEM stage of a CPU.
//   Byte addresses are reduced to a word index (mem_addr[ADDR_WIDTH+1:2]);
//   higher address bits alias. Misaligned accesses (mem_addr[1:0] != 0) raise
//   mem_err for the completion cycle, return 0 and neither write nor count.
//   Read data in the completion cycle is always the pre-write word.
//
//   Build option: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per
//   access (IDLE -> WAIT -> DONE FSM, request captured on entry). Without it,
//   every request cycle completes combinationally and mem_stall is tied low.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   mem_ren    in   read request
//   mem_wen    in   write request
//   mem_addr   in   32-bit byte address
//   mem_dout   in   32-bit write data from CPU
//   mem_din    out  32-bit read data to CPU (0 outside a good completion)
//   mem_stall  out  access still in progress; requester holds inputs
//   mem_err    out  misalignment flag, completion cycle only
//   rd_count   out  completed read count (wraps)
//   wr_count   out  completed write count (wraps)
// -----------------------------------------------------------------------------
module data_mem_resp #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  logic                  req;
  logic                  req_mis;
  logic [ADDR_WIDTH-1:0] req_idx;

  assign req     = mem_ren | mem_wen;
  assign req_mis = |mem_addr[1:0];
  assign req_idx = mem_addr[ADDR_WIDTH+1:2];

  // Upper address bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

  // Completion-cycle view of the access, shared by storage and counters.
  logic                  cmp_fire;
  logic                  cmp_ren;
  logic                  cmp_wen;
  logic                  cmp_mis;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic [31:0]           cmp_wdata;

`ifdef DMEM_WAIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    mis_d     = mis_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    mem_din   = '0;
    case (state_q)
      IDLE: begin
        if (req && !rst) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
          cnt_d     = 4'(WAIT_CYCLES - 1);
          ren_d     = mem_ren;
          wen_d     = mem_wen;
          mis_d     = req_mis;
          idx_d     = req_idx;
          wdata_d   = mem_dout;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        // Leave on count 1 (or 0) so the access spans WAIT_CYCLES+1 cycles
        // including the IDLE request cycle and the DONE cycle.
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
          rdata_d = mis_q ? '0 : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        mem_din = rdata_q;
        mem_err = mis_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp_fire  = (state_q == DONE) & ~rst;
  assign cmp_ren   = ren_q;
  assign cmp_wen   = wen_q;
  assign cmp_mis   = mis_q;
  assign cmp_idx   = idx_q;
  assign cmp_wdata = wdata_q;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);

  assign mem_stall = 1'b0;
  assign mem_err   = req & req_mis & ~rst;
  assign mem_din   = (req && !req_mis && !rst) ? mem_q[req_idx] : '0;

  assign cmp_fire  = req & ~rst;
  assign cmp_ren   = mem_ren;
  assign cmp_wen   = mem_wen;
  assign cmp_mis   = req_mis;
  assign cmp_idx   = req_idx;
  assign cmp_wdata = mem_dout;
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cmp_fire && cmp_wen && !cmp_mis) begin
      mem_q[cmp_idx] <= cmp_wdata;
    end
  end

  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (cmp_fire && !cmp_mis) begin
      if (cmp_ren) rd_count_q <= rd_count_q + 32'd1;
      if (cmp_wen) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  data_mem_resp #(
    .ADDR_WIDTH (8),
    .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_stall(mem_stall),
    .mem_err  (mem_err),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_din;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_wr = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one access, waits out any stall, checks the completion cycle,
  // then lets the completing edge pass and checks the counters.
  task automatic access(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    mem_ren  = v.ren;
    mem_wen  = v.wen;
    mem_addr = v.addr;
    mem_dout = v.wdata;
    #1;
    n = 0;
    while (mem_stall && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (mem_stall) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: stall still %b expected 0", tag, mem_stall);
    end else begin
      if (v.chk_din) check32({tag, " din"}, mem_din, v.exp_din);
      check32({tag, " err"}, {31'b0, mem_err}, {31'b0, v.exp_err});
    end
    if (v.addr[1:0] == 2'b00) begin
      if (v.ren) exp_rd = exp_rd + 32'd1;
      if (v.wen) exp_wr = exp_wr + 32'd1;
    end
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    check32({tag, " rd_count"}, rd_count, exp_rd);
    check32({tag, " wr_count"}, wr_count, exp_wr);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          ren   wen   addr          wdata         chk   exp_din       err
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1, 32'h1111_1111, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h2222_2222, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_F3FC, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0013, 32'h5555_5555, 1'b1, 32'h0,        1'b1};

    rst      = 1'b1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check32("reset stall", {31'b0, mem_stall}, 32'h0);
    check32("reset err", {31'b0, mem_err}, 32'h0);
    check32("reset din", mem_din, 32'h0);
    check32("reset rd_count", rd_count, 32'h0);
    check32("reset wr_count", wr_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      access(vecs[i], $sformatf("v%0d", i));
    end

    // No request: outputs idle even with an address of populated memory.
    @(negedge clk);
    mem_addr = 32'h0000_0010;
    #1;
    check32("idle din", mem_din, 32'h0);
    check32("idle stall", {31'b0, mem_stall}, 32'h0);
    check32("idle err", {31'b0, mem_err}, 32'h0);

`ifdef DMEM_WAIT_EN
    // Read at cycle N: stall in N and N+1, data in N+2.
    @(negedge clk);
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_0010;
    #1;
    check32("wt N stall", {31'b0, mem_stall}, 32'h1);
    @(negedge clk);
    #1;
    check32("wt N+1 stall", {31'b0, mem_stall}, 32'h1);
    @(negedge clk);
    #1;
    check32("wt N+2 stall", {31'b0, mem_stall}, 32'h0);
    check32("wt N+2 din", mem_din, 32'hDEAD_BEEF);
    exp_rd = exp_rd + 32'd1;
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    check32("wt rd_count", rd_count, exp_rd);
`endif

    v = '{1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0};
    access(v, "pre40");

    // Reset in the middle of a read+write to 0x40.
    @(negedge clk);
    mem_ren  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0040;
    mem_dout = 32'hFFFF_FFFF;
`ifdef DMEM_WAIT_EN
    @(posedge clk);
    #1;
    check32("mid stall", {31'b0, mem_stall}, 32'h1);
`else
    #1;
    check32("mid din", mem_din, 32'h0BAD_F00D);
`endif
    #1;
    rst = 1'b1;
    #1;
    check32("arst stall", {31'b0, mem_stall}, 32'h0);
    check32("arst din", mem_din, 32'h0);
    check32("arst err", {31'b0, mem_err}, 32'h0);
    check32("arst rd_count", rd_count, 32'h0);
    check32("arst wr_count", wr_count, 32'h0);
    @(negedge clk);
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0;
    exp_wr = '0;

    v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0};
    access(v, "post40");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
